aes_inv_subbytes_seq: RTL and testbench
=======================================

AES_INV_SUBBYTES_SEQ -- requirements
Module: aes_inv_subbytes_seq

Interface
REQ-001 Parameter: NUM_LANES, 1, inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is a elaboration error.
REQ-002 Derived constant: ITER = 16/NUM_LANES, the number of SUB cycles per block.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: in_valid  input  1  in_data holds a valid 128-bit state.
REQ-006 Port: in_ready  output  1  block can accept a state.
REQ-007 Port: in_data  input  128  ciphertext-side state; byte 0 = [127:120], byte 15 = [7:0].
REQ-008 Port: out_valid  output  1  out_data holds a completed InvSubBytes result.
REQ-009 Port: out_ready  input  1  downstream accepts out_data.
REQ-010 Port: out_data  output  128  result; byte i = InvSbox(in byte i), same byte ordering as in_data.

Function
REQ-011 FSM states: IDLE, SUB, DONE; encoding free.
REQ-012 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; both are registered-state decodes.
REQ-013 IDLE: on in_valid & in_ready, capture in_data into the working register, clear lane counter cnt to 0, go to SUB; otherwise stay in IDLE.
REQ-014 SUB: each cycle, replace bytes cnt*NUM_LANES .. cnt*NUM_LANES+NUM_LANES-1 of the working register with their InvSbox values, then increment cnt.
REQ-015 SUB: in the cycle where cnt = ITER-1, write the last lane group, clear cnt to 0, go to DONE.
REQ-016 cnt width = max(1, clog2(ITER)) bits; cnt never exceeds ITER-1.
REQ-017 Latency: out_valid first rises exactly ITER clock edges after the accepting edge (16 for NUM_LANES=1, 1 for NUM_LANES=16).
REQ-018 DONE: out_data = working register, held stable while out_valid=1 and out_ready=0.
REQ-019 DONE: on out_ready=1, go to IDLE. in_valid is ignored in the same cycle because in_ready=0; the next accept is possible one cycle later at the earliest.
REQ-020 in_valid is ignored in SUB and DONE. in_data changes after acceptance have no effect on the result.
REQ-021 out_ready is ignored outside DONE.
REQ-022 Throughput: one block per ITER+2 cycles when out_ready is held high and in_valid is continuous.
REQ-023 InvSbox is the FIPS-197 inverse substitution table and is the exact inverse of the team's forward sbox for all 256 inputs.
REQ-024 The lookup is purely combinational, from the working-register byte to the new byte, with no extra pipeline stage.

Reset
REQ-025 While rst=1 at a clock edge: state goes to IDLE, cnt goes to 0, working register goes to 128'h0.
REQ-026 Output values after reset: in_ready=1, out_valid=0, out_data=128'h0.
REQ-027 Reset asserted in SUB or DONE abandons the block with no output handshake. rst has priority over every other input in the same cycle.

Structure
REQ-028 A shared package aes_pkg holds the state-width constant (128), the byte-count constant (16), the FSM state typedef and the inverse-table constant if it is kept as an array.
REQ-029 One sub-module, inv_sbox (8-bit data in, 8-bit dout out, combinational, case table), is instantiated NUM_LANES times and selected by cnt.

Verification
REQ-030 NUM_LANES=1, in_data=637c777bf26b6fc53001672bfed7ab76, out_ready=1 -> out_valid rises 16 edges after acceptance with out_data=000102030405060708090a0b0c0d0e0f.
REQ-031 Exhaustive check: 16 blocks covering byte inputs 00..ff. Every byte must satisfy InvSbox(Sbox(x))=x against the forward sbox model. Spot checks: 63->00, 16->ff, 00->52.
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_data is unchanged, in_ready stays 0. When out_ready goes to 1, the next cycle is IDLE with in_ready=1.
REQ-033 rst pulsed for 1 cycle when cnt=7 (NUM_LANES=1) -> next cycle IDLE, out_valid=0, out_data=0. A following block of all 63 bytes returns all 00 bytes.
REQ-034 in_valid held high with in_data toggling every cycle during SUB -> only the first accepted value is processed, and the second accept happens 1 cycle after the out handshake.
REQ-035 Repeat REQ-030 for NUM_LANES=2, 4, 8, 16 -> identical out_data with latencies of 8, 4, 2 and 1 edges.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and FSM state type for the InvSubBytes block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int NBYTES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none (pure lookup).
// Ports: din - byte to substitute; dout - inverse S-box value of din.
module inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    always_comb begin
        dout = 8'h00;
        case (din)
            8'h00: dout = 8'h52; 8'h01: dout = 8'h09; 8'h02: dout = 8'h6a; 8'h03: dout = 8'hd5; 8'h04: dout = 8'h30; 8'h05: dout = 8'h36; 8'h06: dout = 8'ha5; 8'h07: dout = 8'h38;
            8'h08: dout = 8'hbf; 8'h09: dout = 8'h40; 8'h0a: dout = 8'ha3; 8'h0b: dout = 8'h9e; 8'h0c: dout = 8'h81; 8'h0d: dout = 8'hf3; 8'h0e: dout = 8'hd7; 8'h0f: dout = 8'hfb;
            8'h10: dout = 8'h7c; 8'h11: dout = 8'he3; 8'h12: dout = 8'h39; 8'h13: dout = 8'h82; 8'h14: dout = 8'h9b; 8'h15: dout = 8'h2f; 8'h16: dout = 8'hff; 8'h17: dout = 8'h87;
            8'h18: dout = 8'h34; 8'h19: dout = 8'h8e; 8'h1a: dout = 8'h43; 8'h1b: dout = 8'h44; 8'h1c: dout = 8'hc4; 8'h1d: dout = 8'hde; 8'h1e: dout = 8'he9; 8'h1f: dout = 8'hcb;
            8'h20: dout = 8'h54; 8'h21: dout = 8'h7b; 8'h22: dout = 8'h94; 8'h23: dout = 8'h32; 8'h24: dout = 8'ha6; 8'h25: dout = 8'hc2; 8'h26: dout = 8'h23; 8'h27: dout = 8'h3d;
            8'h28: dout = 8'hee; 8'h29: dout = 8'h4c; 8'h2a: dout = 8'h95; 8'h2b: dout = 8'h0b; 8'h2c: dout = 8'h42; 8'h2d: dout = 8'hfa; 8'h2e: dout = 8'hc3; 8'h2f: dout = 8'h4e;
            8'h30: dout = 8'h08; 8'h31: dout = 8'h2e; 8'h32: dout = 8'ha1; 8'h33: dout = 8'h66; 8'h34: dout = 8'h28; 8'h35: dout = 8'hd9; 8'h36: dout = 8'h24; 8'h37: dout = 8'hb2;
            8'h38: dout = 8'h76; 8'h39: dout = 8'h5b; 8'h3a: dout = 8'ha2; 8'h3b: dout = 8'h49; 8'h3c: dout = 8'h6d; 8'h3d: dout = 8'h8b; 8'h3e: dout = 8'hd1; 8'h3f: dout = 8'h25;
            8'h40: dout = 8'h72; 8'h41: dout = 8'hf8; 8'h42: dout = 8'hf6; 8'h43: dout = 8'h64; 8'h44: dout = 8'h86; 8'h45: dout = 8'h68; 8'h46: dout = 8'h98; 8'h47: dout = 8'h16;
            8'h48: dout = 8'hd4; 8'h49: dout = 8'ha4; 8'h4a: dout = 8'h5c; 8'h4b: dout = 8'hcc; 8'h4c: dout = 8'h5d; 8'h4d: dout = 8'h65; 8'h4e: dout = 8'hb6; 8'h4f: dout = 8'h92;
            8'h50: dout = 8'h6c; 8'h51: dout = 8'h70; 8'h52: dout = 8'h48; 8'h53: dout = 8'h50; 8'h54: dout = 8'hfd; 8'h55: dout = 8'hed; 8'h56: dout = 8'hb9; 8'h57: dout = 8'hda;
            8'h58: dout = 8'h5e; 8'h59: dout = 8'h15; 8'h5a: dout = 8'h46; 8'h5b: dout = 8'h57; 8'h5c: dout = 8'ha7; 8'h5d: dout = 8'h8d; 8'h5e: dout = 8'h9d; 8'h5f: dout = 8'h84;
            8'h60: dout = 8'h90; 8'h61: dout = 8'hd8; 8'h62: dout = 8'hab; 8'h63: dout = 8'h00; 8'h64: dout = 8'h8c; 8'h65: dout = 8'hbc; 8'h66: dout = 8'hd3; 8'h67: dout = 8'h0a;
            8'h68: dout = 8'hf7; 8'h69: dout = 8'he4; 8'h6a: dout = 8'h58; 8'h6b: dout = 8'h05; 8'h6c: dout = 8'hb8; 8'h6d: dout = 8'hb3; 8'h6e: dout = 8'h45; 8'h6f: dout = 8'h06;
            8'h70: dout = 8'hd0; 8'h71: dout = 8'h2c; 8'h72: dout = 8'h1e; 8'h73: dout = 8'h8f; 8'h74: dout = 8'hca; 8'h75: dout = 8'h3f; 8'h76: dout = 8'h0f; 8'h77: dout = 8'h02;
            8'h78: dout = 8'hc1; 8'h79: dout = 8'haf; 8'h7a: dout = 8'hbd; 8'h7b: dout = 8'h03; 8'h7c: dout = 8'h01; 8'h7d: dout = 8'h13; 8'h7e: dout = 8'h8a; 8'h7f: dout = 8'h6b;
            8'h80: dout = 8'h3a; 8'h81: dout = 8'h91; 8'h82: dout = 8'h11; 8'h83: dout = 8'h41; 8'h84: dout = 8'h4f; 8'h85: dout = 8'h67; 8'h86: dout = 8'hdc; 8'h87: dout = 8'hea;
            8'h88: dout = 8'h97; 8'h89: dout = 8'hf2; 8'h8a: dout = 8'hcf; 8'h8b: dout = 8'hce; 8'h8c: dout = 8'hf0; 8'h8d: dout = 8'hb4; 8'h8e: dout = 8'he6; 8'h8f: dout = 8'h73;
            8'h90: dout = 8'h96; 8'h91: dout = 8'hac; 8'h92: dout = 8'h74; 8'h93: dout = 8'h22; 8'h94: dout = 8'he7; 8'h95: dout = 8'had; 8'h96: dout = 8'h35; 8'h97: dout = 8'h85;
            8'h98: dout = 8'he2; 8'h99: dout = 8'hf9; 8'h9a: dout = 8'h37; 8'h9b: dout = 8'he8; 8'h9c: dout = 8'h1c; 8'h9d: dout = 8'h75; 8'h9e: dout = 8'hdf; 8'h9f: dout = 8'h6e;
            8'ha0: dout = 8'h47; 8'ha1: dout = 8'hf1; 8'ha2: dout = 8'h1a; 8'ha3: dout = 8'h71; 8'ha4: dout = 8'h1d; 8'ha5: dout = 8'h29; 8'ha6: dout = 8'hc5; 8'ha7: dout = 8'h89;
            8'ha8: dout = 8'h6f; 8'ha9: dout = 8'hb7; 8'haa: dout = 8'h62; 8'hab: dout = 8'h0e; 8'hac: dout = 8'haa; 8'had: dout = 8'h18; 8'hae: dout = 8'hbe; 8'haf: dout = 8'h1b;
            8'hb0: dout = 8'hfc; 8'hb1: dout = 8'h56; 8'hb2: dout = 8'h3e; 8'hb3: dout = 8'h4b; 8'hb4: dout = 8'hc6; 8'hb5: dout = 8'hd2; 8'hb6: dout = 8'h79; 8'hb7: dout = 8'h20;
            8'hb8: dout = 8'h9a; 8'hb9: dout = 8'hdb; 8'hba: dout = 8'hc0; 8'hbb: dout = 8'hfe; 8'hbc: dout = 8'h78; 8'hbd: dout = 8'hcd; 8'hbe: dout = 8'h5a; 8'hbf: dout = 8'hf4;
            8'hc0: dout = 8'h1f; 8'hc1: dout = 8'hdd; 8'hc2: dout = 8'ha8; 8'hc3: dout = 8'h33; 8'hc4: dout = 8'h88; 8'hc5: dout = 8'h07; 8'hc6: dout = 8'hc7; 8'hc7: dout = 8'h31;
            8'hc8: dout = 8'hb1; 8'hc9: dout = 8'h12; 8'hca: dout = 8'h10; 8'hcb: dout = 8'h59; 8'hcc: dout = 8'h27; 8'hcd: dout = 8'h80; 8'hce: dout = 8'hec; 8'hcf: dout = 8'h5f;
            8'hd0: dout = 8'h60; 8'hd1: dout = 8'h51; 8'hd2: dout = 8'h7f; 8'hd3: dout = 8'ha9; 8'hd4: dout = 8'h19; 8'hd5: dout = 8'hb5; 8'hd6: dout = 8'h4a; 8'hd7: dout = 8'h0d;
            8'hd8: dout = 8'h2d; 8'hd9: dout = 8'he5; 8'hda: dout = 8'h7a; 8'hdb: dout = 8'h9f; 8'hdc: dout = 8'h93; 8'hdd: dout = 8'hc9; 8'hde: dout = 8'h9c; 8'hdf: dout = 8'hef;
            8'he0: dout = 8'ha0; 8'he1: dout = 8'he0; 8'he2: dout = 8'h3b; 8'he3: dout = 8'h4d; 8'he4: dout = 8'hae; 8'he5: dout = 8'h2a; 8'he6: dout = 8'hf5; 8'he7: dout = 8'hb0;
            8'he8: dout = 8'hc8; 8'he9: dout = 8'heb; 8'hea: dout = 8'hbb; 8'heb: dout = 8'h3c; 8'hec: dout = 8'h83; 8'hed: dout = 8'h53; 8'hee: dout = 8'h99; 8'hef: dout = 8'h61;
            8'hf0: dout = 8'h17; 8'hf1: dout = 8'h2b; 8'hf2: dout = 8'h04; 8'hf3: dout = 8'h7e; 8'hf4: dout = 8'hba; 8'hf5: dout = 8'h77; 8'hf6: dout = 8'hd6; 8'hf7: dout = 8'h26;
            8'hf8: dout = 8'he1; 8'hf9: dout = 8'h69; 8'hfa: dout = 8'h14; 8'hfb: dout = 8'h63; 8'hfc: dout = 8'h55; 8'hfd: dout = 8'h21; 8'hfe: dout = 8'h0c; 8'hff: dout = 8'h7d;
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Sequential AES InvSubBytes over a 128-bit state, NUM_LANES bytes per cycle.
// Latency: out_valid rises 16/NUM_LANES edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data accept a state;
//        out_valid/out_ready/out_data return the substituted state (byte 0 = MSB).
module aes_inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    localparam int ITER  = NBYTES / NUM_LANES;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    generate
        if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4 ||
              NUM_LANES == 8 || NUM_LANES == 16)) begin : g_bad_lanes
            $error("aes_inv_subbytes_seq: NUM_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] work_q, work_d;

    logic [7:0] lane_in  [NUM_LANES];
    logic [7:0] lane_out [NUM_LANES];
    logic [6:0] lane_lsb [NUM_LANES];

    // Lane l handles byte cnt*NUM_LANES+l; byte 0 sits in the top byte of the state.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_lsb[l] = 7'(8 * (NBYTES - 1 - (int'(cnt_q) * NUM_LANES + l)));
            lane_in[l]  = work_q[lane_lsb[l] +: 8];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    work_d[lane_lsb[l] +: 8] = lane_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Self-checking bench for aes_inv_subbytes_seq across all legal lane counts.
// Latency: n/a (testbench).
// Backpressure: drives out_ready directly to exercise hold and release.
module tb_aes_inv_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic [4:0]   in_ready_v;
    logic [4:0]   out_valid_v;
    logic [127:0] out_data_a [5];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   fwd_sbox [256];
    logic [7:0]   inv_ref  [256];
    int           lat_a [5];
    logic [127:0] res_a [5];

    localparam logic [127:0] KAT_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] KAT_OUT = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_inv_subbytes_seq #(.NUM_LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_a[g])
        );
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: forward S-box from GF(2^8) inversion plus affine map, then inverted.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] inv, x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            end
            fwd_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_ref[fwd_sbox[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_ref[d[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // All instances accept d together; records each one's first out_valid edge and data.
    task automatic accept_and_track(input logic [127:0] d);
        bit all_done;
        for (int g = 0; g < 5; g++) begin lat_a[g] = -1; res_a[g] = 'x; end
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            all_done = 1'b1;
            for (int g = 0; g < 5; g++) begin
                if (lat_a[g] < 0) begin
                    if (out_valid_v[g]) begin lat_a[g] = k; res_a[g] = out_data_a[g]; end
                    else all_done = 1'b0;
                end
            end
            if (all_done) break;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (in_ready_v[g] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready lanes=%0d got %b want 1", 1 << g, in_ready_v[g]); end
            n_cmp++;
            if (out_valid_v[g] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid lanes=%0d got %b want 0", 1 << g, out_valid_v[g]); end
            n_cmp++;
            if (out_data_a[g] !== 128'h0) begin n_bad++; $display("FAIL reset_out_data lanes=%0d got %h want 0", 1 << g, out_data_a[g]); end
        end
    endtask

    task automatic test_known_vector();
        accept_and_track(KAT_IN);
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (lat_a[g] !== (16 >> g)) begin n_bad++; $display("FAIL kat_latency lanes=%0d got %0d want %0d", 1 << g, lat_a[g], 16 >> g); end
            n_cmp++;
            if (res_a[g] !== KAT_OUT) begin n_bad++; $display("FAIL kat_data lanes=%0d got %h want %h", 1 << g, res_a[g], KAT_OUT); end
        end
    endtask

    task automatic test_exhaustive();
        logic [127:0] d, exp;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                d[127 - 8*i -: 8]   = fwd_sbox[b*16 + i];
                exp[127 - 8*i -: 8] = 8'(b*16 + i);
            end
            accept_and_track(d);
            for (int g = 0; g < 5; g++) begin
                n_cmp++;
                if (res_a[g] !== exp) begin n_bad++; $display("FAIL exhaustive blk=%0d lanes=%0d got %h want %h", b, 1 << g, res_a[g], exp); end
            end
        end
        d = rand128();
        d[127:104] = 24'h631600;
        accept_and_track(d);
        n_cmp++;
        if (res_a[0][127:120] !== 8'h00) begin n_bad++; $display("FAIL spot_63 got %h want 00", res_a[0][127:120]); end
        n_cmp++;
        if (res_a[0][119:112] !== 8'hff) begin n_bad++; $display("FAIL spot_16 got %h want ff", res_a[0][119:112]); end
        n_cmp++;
        if (res_a[0][111:104] !== 8'h52) begin n_bad++; $display("FAIL spot_00 got %h want 52", res_a[0][111:104]); end
    endtask

    task automatic test_random();
        logic [127:0] d;
        for (int r = 0; r < 6; r++) begin
            d = rand128();
            accept_and_track(d);
            for (int g = 0; g < 5; g++) begin
                n_cmp++;
                if (res_a[g] !== model(d) || lat_a[g] !== (16 >> g)) begin
                    n_bad++;
                    $display("FAIL random lanes=%0d got %h lat %0d want %h lat %0d", 1 << g, res_a[g], lat_a[g], model(d), 16 >> g);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, exp;
        bit seen;
        d = rand128(); exp = model(d); seen = 1'b0;
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = out_valid_v[0];
        end
        n_cmp++;
        if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_timeout got %b want 1", seen); end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = rand128();
            tick();
            n_cmp++;
            if (out_valid_v[0] !== 1'b1 || out_data_a[0] !== exp || in_ready_v[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", k, out_valid_v[0], out_data_a[0], in_ready_v[0], exp);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", in_ready_v[0], out_valid_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit stray;
        in_valid = 1'b1; in_data = rand128(); out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (in_ready_v[g] !== 1'b1 || out_valid_v[g] !== 1'b0 || out_data_a[g] !== 128'h0) begin
                n_bad++;
                $display("FAIL midreset lanes=%0d got rdy=%b v=%b d=%h want 1 0 0", 1 << g, in_ready_v[g], out_valid_v[g], out_data_a[g]);
            end
        end
        stray = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid_v !== 5'b0) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin n_bad++; $display("FAIL midreset_stray_output got %b want 0", stray); end
        accept_and_track({16{8'h63}});
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (res_a[g] !== 128'h0) begin n_bad++; $display("FAIL midreset_all63 lanes=%0d got %h want 0", 1 << g, res_a[g]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] acc_d[$];
        logic [127:0] res_q[$];
        int           acc_n[$];
        int           hs_n[$];
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            in_data = rand128();
            if (in_ready_v[0]) begin acc_d.push_back(in_data); acc_n.push_back(n); end
            if (out_valid_v[0]) begin res_q.push_back(out_data_a[0]); hs_n.push_back(n); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (acc_d.size() < 2 || res_q.size() < 2) begin
            n_bad++;
            $display("FAIL b2b_counts got acc=%0d out=%0d want >=2 each", acc_d.size(), res_q.size());
        end else begin
            n_cmp++;
            if (res_q[0] !== model(acc_d[0])) begin n_bad++; $display("FAIL b2b_first_data got %h want %h", res_q[0], model(acc_d[0])); end
            n_cmp++;
            if (res_q[1] !== model(acc_d[1])) begin n_bad++; $display("FAIL b2b_second_data got %h want %h", res_q[1], model(acc_d[1])); end
            n_cmp++;
            if (acc_n[1] !== hs_n[0] + 1) begin n_bad++; $display("FAIL b2b_reaccept got cyc %0d want %0d", acc_n[1], hs_n[0] + 1); end
            n_cmp++;
            if (acc_n[1] - acc_n[0] !== 18) begin n_bad++; $display("FAIL b2b_period got %0d want 18", acc_n[1] - acc_n[0]); end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        build_model();
        test_reset();
        test_known_vector();
        test_exhaustive();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
